// File: rtl/rv32_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: PC mux select codes,
// boot address, sequencer state encoding and a PC alignment helper.
package rv32_pkg;

  localparam logic [31:0] BOOT_ADDR = 32'h0000_0000;

  localparam logic [1:0] SRC_BOOT = 2'b00;
  localparam logic [1:0] SRC_EPC  = 2'b01;
  localparam logic [1:0] SRC_TRAP = 2'b10;
  localparam logic [1:0] SRC_NEXT = 2'b11;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    REDIR = 2'b10
  } pc_state_t;

  // Instructions are at least halfword aligned, so bit 0 of a loaded PC is always clear.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// PC sequencer for the fetch stage: selects the PC mux source, holds the
// architectural PC and only updates it when the instruction bus is ready and
// the pipeline is not stalled. Trap/mret events seen while the PC cannot
// advance are remembered until the next advance cycle.
// Optional feature macro: RV32_MISALIGN_TRAP_EN -- a taken branch to a target
// with bit 1 set is not loaded; instead the next advance loads the trap vector.
module pc_sequencer
  import rv32_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ahb_ready_in,
  input  logic        stall_in,
  input  logic        trap_req_in,
  input  logic        mret_in,
  input  logic        branch_taken_in,
  input  logic [31:0] pc_mux_in,
  output logic [1:0]  pc_src_out,
  output logic [31:0] pc_out,
  output logic        pc_load_out,
  output logic        flush_out,
  output logic        trap_taken_out
);

  pc_state_t   state_r;
  logic        pend_trap_r;
  logic        pend_mret_r;
  logic [31:0] pc_r;
  logic        pc_load_r;
  logic        flush_r;
  logic        trap_taken_r;

  logic        advance_s;
  logic        sel_trap_s;
  logic        sel_mret_s;
  logic        misalign_s;
  logic [1:0]  pc_src_s;

  // Event priority encoder: trap (new or pending) beats mret beats sequential/branch flow.
  always_comb begin
    advance_s  = ahb_ready_in & ~stall_in;
    sel_trap_s = 1'b0;
    sel_mret_s = 1'b0;
    pc_src_s   = SRC_BOOT;
`ifdef RV32_MISALIGN_TRAP_EN
    misalign_s = branch_taken_in & pc_mux_in[1];
`else
    misalign_s = 1'b0;
`endif
    case (state_r)
      BOOT: begin
        pc_src_s = SRC_BOOT;
      end
      RUN: begin
        if (pend_trap_r | trap_req_in) begin
          sel_trap_s = 1'b1;
          pc_src_s   = SRC_TRAP;
        end else if (pend_mret_r | mret_in) begin
          sel_mret_s = 1'b1;
          pc_src_s   = SRC_EPC;
        end else begin
          pc_src_s   = SRC_NEXT;
        end
      end
`ifdef RV32_MISALIGN_TRAP_EN
      REDIR: begin
        pc_src_s = SRC_TRAP;
      end
`endif
      default: begin
        pc_src_s = SRC_BOOT;
      end
    endcase
  end

  // Sequencer FSM: PC register, pending-event flags and one-cycle commit pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r      <= BOOT;
      pc_r         <= BOOT_ADDR;
      pend_trap_r  <= 1'b0;
      pend_mret_r  <= 1'b0;
      pc_load_r    <= 1'b0;
      flush_r      <= 1'b0;
      trap_taken_r <= 1'b0;
    end else begin
      pc_load_r    <= 1'b0;
      flush_r      <= 1'b0;
      trap_taken_r <= 1'b0;
      case (state_r)
        BOOT: begin
          // Events are not meaningful before the first fetch; they are dropped.
          if (advance_s) begin
            pc_r      <= align_pc(pc_mux_in);
            pc_load_r <= 1'b1;
            state_r   <= RUN;
          end
        end
        RUN: begin
          if (advance_s) begin
            if (sel_trap_s) begin
              // A trap supersedes any mret waiting alongside it.
              pc_r         <= align_pc(pc_mux_in);
              pc_load_r    <= 1'b1;
              flush_r      <= 1'b1;
              trap_taken_r <= 1'b1;
              pend_trap_r  <= 1'b0;
              pend_mret_r  <= 1'b0;
            end else if (sel_mret_s) begin
              pc_r        <= align_pc(pc_mux_in);
              pc_load_r   <= 1'b1;
              flush_r     <= 1'b1;
              pend_mret_r <= 1'b0;
            end else if (misalign_s) begin
              // Misaligned branch target: hold the PC and take the trap next advance.
              state_r <= REDIR;
            end else begin
              pc_r      <= align_pc(pc_mux_in);
              pc_load_r <= 1'b1;
              flush_r   <= branch_taken_in;
            end
          end else begin
            // Repeated requests collapse into the single flag (no queueing).
            if (trap_req_in) begin
              pend_trap_r <= 1'b1;
            end
            if (mret_in) begin
              pend_mret_r <= 1'b1;
            end
          end
        end
`ifdef RV32_MISALIGN_TRAP_EN
        REDIR: begin
          if (advance_s) begin
            pc_r         <= align_pc(pc_mux_in);
            pc_load_r    <= 1'b1;
            flush_r      <= 1'b1;
            trap_taken_r <= 1'b1;
            pend_trap_r  <= 1'b0;
            pend_mret_r  <= 1'b0;
            state_r      <= RUN;
          end
        end
`endif
        default: begin
          state_r     <= BOOT;
          pend_trap_r <= 1'b0;
          pend_mret_r <= 1'b0;
        end
      endcase
    end
  end

  assign pc_src_out     = pc_src_s;
  assign pc_out         = pc_r;
  assign pc_load_out    = pc_load_r;
  assign flush_out      = flush_r;
  assign trap_taken_out = trap_taken_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized run compared against a behavioural model of the PC sequencing rules.
module tb_pc_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        ahb_ready_in;
  logic        stall_in;
  logic        trap_req_in;
  logic        mret_in;
  logic        branch_taken_in;
  logic [31:0] pc_mux_in;
  logic [1:0]  pc_src_out;
  logic [31:0] pc_out;
  logic        pc_load_out;
  logic        flush_out;
  logic        trap_taken_out;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: has the core fetched yet, is a misalignment trap owed,
  // which events are waiting, and what the outputs should read after each edge.
  bit          m_started;
  bit          m_trap_owed;
  bit          m_wait_trap;
  bit          m_wait_mret;
  logic [31:0] m_pc;
  bit          m_load;
  bit          m_flush;
  bit          m_taken;

  logic [1:0]  obs_src;
  logic [1:0]  exp_src;

  pc_sequencer dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .ahb_ready_in    (ahb_ready_in),
    .stall_in        (stall_in),
    .trap_req_in     (trap_req_in),
    .mret_in         (mret_in),
    .branch_taken_in (branch_taken_in),
    .pc_mux_in       (pc_mux_in),
    .pc_src_out      (pc_src_out),
    .pc_out          (pc_out),
    .pc_load_out     (pc_load_out),
    .flush_out       (flush_out),
    .trap_taken_out  (trap_taken_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_reset();
    m_started   = 1'b0;
    m_trap_owed = 1'b0;
    m_wait_trap = 1'b0;
    m_wait_mret = 1'b0;
    m_pc        = 32'h0000_0000;
    m_load      = 1'b0;
    m_flush     = 1'b0;
    m_taken     = 1'b0;
  endfunction

  // Which PC mux source the sequencer should be asking for right now.
  function automatic logic [1:0] model_src();
    if (!m_started) return 2'b00;
    if (m_trap_owed || m_wait_trap || trap_req_in) return 2'b10;
    if (m_wait_mret || mret_in) return 2'b01;
    return 2'b11;
  endfunction

  // What the next rising edge does, given the inputs currently applied.
  function automatic void model_edge();
    bit go;
    bit misaligned;
    logic [1:0] want;
    go = ahb_ready_in && !stall_in;
    want = model_src();
`ifdef RV32_MISALIGN_TRAP_EN
    misaligned = branch_taken_in && pc_mux_in[1];
`else
    misaligned = 1'b0;
`endif
    m_load  = 1'b0;
    m_flush = 1'b0;
    m_taken = 1'b0;
    if (!go) begin
      if (m_started && !m_trap_owed) begin
        m_wait_trap = m_wait_trap | trap_req_in;
        m_wait_mret = m_wait_mret | mret_in;
      end
    end else if (!m_started) begin
      m_pc = pc_mux_in & 32'hFFFF_FFFE;
      m_load = 1'b1;
      m_started = 1'b1;
    end else if (want == 2'b10) begin
      m_pc = pc_mux_in & 32'hFFFF_FFFE;
      m_load = 1'b1; m_flush = 1'b1; m_taken = 1'b1;
      m_trap_owed = 1'b0; m_wait_trap = 1'b0; m_wait_mret = 1'b0;
    end else if (want == 2'b01) begin
      m_pc = pc_mux_in & 32'hFFFF_FFFE;
      m_load = 1'b1; m_flush = 1'b1;
      m_wait_mret = 1'b0;
    end else if (misaligned) begin
      m_trap_owed = 1'b1;
    end else begin
      m_pc = pc_mux_in & 32'hFFFF_FFFE;
      m_load = 1'b1;
      m_flush = branch_taken_in;
    end
  endfunction

  // Apply one cycle of inputs: sample the select before the edge, then step the model.
  task automatic drive_cycle(input logic rdy, input logic stl, input logic trp,
                             input logic mrt, input logic br, input logic [31:0] mux);
    @(negedge clk_in);
    ahb_ready_in = rdy; stall_in = stl; trap_req_in = trp;
    mret_in = mrt; branch_taken_in = br; pc_mux_in = mux;
    #1;
    obs_src = pc_src_out;
    exp_src = model_src();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; ahb_ready_in = 1'b0; stall_in = 1'b0; trap_req_in = 1'b0;
    mret_in = 1'b0; branch_taken_in = 1'b0; pc_mux_in = 32'h0;
    model_reset();
    #22;
    vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    vectors++; if (pc_src_out !== 2'b00) begin miscompares++; $display("FAIL reset_src got=%b exp=00", pc_src_out); end
    vectors++; if ({pc_load_out, flush_out, trap_taken_out} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses got=%b exp=000", {pc_load_out, flush_out, trap_taken_out}); end
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_boot();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (obs_src !== 2'b00) begin miscompares++; $display("FAIL boot_src got=%b exp=00", obs_src); end
    vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL boot_pc got=%h exp=%h", pc_out, 32'h0); end
    vectors++; if (pc_load_out !== 1'b1) begin miscompares++; $display("FAIL boot_load got=%b exp=1", pc_load_out); end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    vectors++; if (obs_src !== 2'b11) begin miscompares++; $display("FAIL run_src got=%b exp=11", obs_src); end
    vectors++; if (pc_out !== 32'h100) begin miscompares++; $display("FAIL run_pc got=%h exp=%h", pc_out, 32'h100); end
    vectors++; if (flush_out !== 1'b0) begin miscompares++; $display("FAIL run_flush got=%b exp=0", flush_out); end
  endtask

  task automatic test_ready_hold();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
      vectors++; if (pc_out !== 32'h100) begin miscompares++; $display("FAIL hold_pc got=%h exp=%h", pc_out, 32'h100); end
      vectors++; if (pc_load_out !== 1'b0) begin miscompares++; $display("FAIL hold_load got=%b exp=0", pc_load_out); end
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
    vectors++; if (pc_out !== 32'h104) begin miscompares++; $display("FAIL ready_pc got=%h exp=%h", pc_out, 32'h104); end
    vectors++; if (pc_load_out !== 1'b1) begin miscompares++; $display("FAIL ready_load got=%b exp=1", pc_load_out); end
  endtask

  task automatic test_pending_trap();
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80);
    vectors++; if (obs_src !== 2'b10) begin miscompares++; $display("FAIL ptrap_src0 got=%b exp=10", obs_src); end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
    vectors++; if (obs_src !== 2'b10) begin miscompares++; $display("FAIL ptrap_src1 got=%b exp=10", obs_src); end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80);
    vectors++; if (obs_src !== 2'b10) begin miscompares++; $display("FAIL ptrap_src2 got=%b exp=10", obs_src); end
    vectors++; if (pc_out !== 32'h104) begin miscompares++; $display("FAIL ptrap_hold got=%h exp=%h", pc_out, 32'h104); end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80);
    vectors++; if (obs_src !== 2'b10) begin miscompares++; $display("FAIL ptrap_src3 got=%b exp=10", obs_src); end
    vectors++; if (pc_out !== 32'h80) begin miscompares++; $display("FAIL ptrap_pc got=%h exp=%h", pc_out, 32'h80); end
    vectors++; if ({trap_taken_out, flush_out} !== 2'b11) begin miscompares++; $display("FAIL ptrap_pulses got=%b exp=11", {trap_taken_out, flush_out}); end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h84);
    vectors++; if (obs_src !== 2'b11) begin miscompares++; $display("FAIL ptrap_mret_drop got=%b exp=11", obs_src); end
    vectors++; if ({trap_taken_out, flush_out} !== 2'b00) begin miscompares++; $display("FAIL ptrap_oneshot got=%b exp=00", {trap_taken_out, flush_out}); end
  endtask

  task automatic test_mret();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2000);
    vectors++; if (obs_src !== 2'b01) begin miscompares++; $display("FAIL mret_src got=%b exp=01", obs_src); end
    vectors++; if (pc_out !== 32'h2000) begin miscompares++; $display("FAIL mret_pc got=%h exp=%h", pc_out, 32'h2000); end
    vectors++; if ({flush_out, trap_taken_out} !== 2'b10) begin miscompares++; $display("FAIL mret_pulses got=%b exp=10", {flush_out, trap_taken_out}); end
  endtask

  task automatic test_misaligned_branch();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h302);
`ifdef RV32_MISALIGN_TRAP_EN
    vectors++; if (pc_out !== 32'h2000) begin miscompares++; $display("FAIL mis_noload_pc got=%h exp=%h", pc_out, 32'h2000); end
    vectors++; if (pc_load_out !== 1'b0) begin miscompares++; $display("FAIL mis_noload got=%b exp=0", pc_load_out); end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400);
    vectors++; if (obs_src !== 2'b10) begin miscompares++; $display("FAIL mis_redir_src got=%b exp=10", obs_src); end
    vectors++; if (pc_out !== 32'h400) begin miscompares++; $display("FAIL mis_redir_pc got=%h exp=%h", pc_out, 32'h400); end
    vectors++; if (trap_taken_out !== 1'b1) begin miscompares++; $display("FAIL mis_redir_taken got=%b exp=1", trap_taken_out); end
`else
    vectors++; if (pc_out !== 32'h302) begin miscompares++; $display("FAIL mis_pc got=%h exp=%h", pc_out, 32'h302); end
    vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL mis_flush got=%b exp=1", flush_out); end
`endif
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h505);
    vectors++; if (pc_out !== 32'h504) begin miscompares++; $display("FAIL bit0_clear got=%h exp=%h", pc_out, 32'h504); end
    vectors++; if (flush_out !== 1'b0) begin miscompares++; $display("FAIL seq_noflush got=%b exp=0", flush_out); end
  endtask

  task automatic test_back_to_back();
    // Trap and mret together with advance: trap wins, mret is dropped.
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h600);
    vectors++; if (obs_src !== 2'b10) begin miscompares++; $display("FAIL b2b_src got=%b exp=10", obs_src); end
    vectors++; if (trap_taken_out !== 1'b1) begin miscompares++; $display("FAIL b2b_taken got=%b exp=1", trap_taken_out); end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h700);
    vectors++; if (obs_src !== 2'b11) begin miscompares++; $display("FAIL b2b_branch_src got=%b exp=11", obs_src); end
    vectors++; if ({pc_out, flush_out, trap_taken_out} !== {32'h700, 2'b10}) begin miscompares++; $display("FAIL b2b_branch got=%h/%b%b exp=00000700/10", pc_out, flush_out, trap_taken_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) == 0, $urandom());
      vectors++; if (obs_src !== exp_src) begin miscompares++; $display("FAIL rnd_src cyc=%0d got=%b exp=%b", i, obs_src, exp_src); end
      vectors++; if (pc_out !== m_pc) begin miscompares++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc_out, m_pc); end
      vectors++; if (pc_load_out !== m_load) begin miscompares++; $display("FAIL rnd_load cyc=%0d got=%b exp=%b", i, pc_load_out, m_load); end
      vectors++; if (flush_out !== m_flush) begin miscompares++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", i, flush_out, m_flush); end
      vectors++; if (trap_taken_out !== m_taken) begin miscompares++; $display("FAIL rnd_taken cyc=%0d got=%b exp=%b", i, trap_taken_out, m_taken); end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h900);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA00);
    trap_req_in = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    model_reset();
    vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL rst_stall_pc got=%h exp=%h", pc_out, 32'h0); end
    vectors++; if (pc_src_out !== 2'b00) begin miscompares++; $display("FAIL rst_stall_src got=%b exp=00", pc_src_out); end
    @(negedge clk_in);
    stall_in = 1'b0; ahb_ready_in = 1'b0;
    rst_in = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (obs_src !== 2'b00) begin miscompares++; $display("FAIL rst_stall_boot got=%b exp=00", obs_src); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10 + 32'(i * 4));
      vectors++; if (trap_taken_out !== 1'b0) begin miscompares++; $display("FAIL rst_stall_notrap got=%b exp=0", trap_taken_out); end
      vectors++; if (obs_src !== 2'b11) begin miscompares++; $display("FAIL rst_stall_run got=%b exp=11", obs_src); end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_ready_hold();
    test_pending_trap();
    test_mret();
    test_misaligned_branch();
    test_back_to_back();
    test_random();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
